sram_1r1w_param: RTL

Parametrised 1-read/1-write SRAM buffer that succeeds the fixed 64K×128 output buffer. It adds configurable width and depth, per-byte write masks, and a registered read port with a read-enable and a valid flag. A post-reset clear sequencer zeroes every word, and optional read-during-write forwarding is available. It sits between the datapath writer and the output reader as the system output buffer.

---
 rtl/sram_pkg.sv | 39 +++
 rtl/sram_clear_seq.sv | 50 +++++
 rtl/sram_1r1w_param.sv | 108 ++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1R1W SRAM buffer.
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } sram_state_t;

  // Widest word the lane-merge helper handles; callers pad and truncate.
  localparam int unsigned MAX_DATA_W = 1024;
  localparam int unsigned MAX_NB     = 1024;
  localparam int unsigned MAX_LANE_W = 10;

  // Number of write-mask lanes for a given word and lane width.
  function automatic int unsigned nb_of(input int unsigned data_w, input int unsigned byte_w);
    return data_w / byte_w;
  endfunction

  // Number of words addressed by addr_w bits.
  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Merge new_word into old_word on every lane whose mask bit is set.
  function automatic logic [MAX_DATA_W-1:0] lane_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_NB-1:0]     mask,
    input int unsigned           byte_w
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
      if (mask[MAX_LANE_W'(i / byte_w)]) merged[i] = new_word[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Post-reset clear sequencer: sweeps every address once, then parks in READY.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we,
  output logic              init_busy
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam int unsigned CNT_W = ADDR_W + 1;

  sram_state_t      state;
  logic [CNT_W-1:0] cnt;

  // Sweep FSM: one zero-write per cycle, leave CLEAR after the last address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLEAR;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DEPTH - 1)) begin
            state     <= READY;
            init_busy <= 1'b0;
          end
        end
        READY: begin
          state <= READY;
        end
        default: begin
          state     <= CLEAR;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Clear strobe and address are plain decodes of the sweep registers.
  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/sram_1r1w_param.sv
// Parametrised 1R1W SRAM output buffer with byte-lane write masks, a
// registered read port (1 or 2 stages) and a post-reset zeroing sweep.
// Define SRAM_RDW_BYPASS_EN to forward the merged write word to a
// same-address read in the same cycle; otherwise reads are read-before-write.
module sram_1r1w_param
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned BYTE_W  = 8,
  parameter int unsigned OUT_REG = 0
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                WE,
  input  logic [nb_of(DATA_W, BYTE_W)-1:0]    WMask,
  input  logic [ADDR_W-1:0]                   WriteAddress,
  input  logic [DATA_W-1:0]                   WriteBus,
  input  logic                                RE,
  input  logic [ADDR_W-1:0]                   ReadAddress,
  output logic [DATA_W-1:0]                   ReadBus,
  output logic                                RValid,
  output logic                                InitBusy
);

  localparam int unsigned NB    = nb_of(DATA_W, BYTE_W);
  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we;
  logic              init_busy;
  logic              wr_en_c;
  logic              rd_acc_c;
  logic [DATA_W-1:0] wr_word_c;
  logic [DATA_W-1:0] rd_word_c;

  sram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we),
    .init_busy (init_busy)
  );

  assign InitBusy = init_busy;

  // Access gating, write merge and read-word selection.
  always_comb begin
    wr_en_c   = WE && !init_busy && (WMask != NB'(0));
    rd_acc_c  = RE && !init_busy;
    wr_word_c = DATA_W'(lane_merge(MAX_DATA_W'(mem[WriteAddress]),
                                   MAX_DATA_W'(WriteBus),
                                   MAX_NB'(WMask), BYTE_W));
`ifdef SRAM_RDW_BYPASS_EN
    rd_word_c = (wr_en_c && (WriteAddress == ReadAddress)) ? wr_word_c
                                                           : mem[ReadAddress];
`else
    rd_word_c = mem[ReadAddress];
`endif
  end

  // Storage array: the clear sweep has priority, user writes only once READY.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en_c) begin
      mem[WriteAddress] <= wr_word_c;
    end
  end

  generate
    if (OUT_REG == 0) begin : g_rd_1stage
      // Single output stage: data appears one edge after the read is accepted.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          ReadBus <= '0;
          RValid  <= 1'b0;
        end else begin
          RValid <= rd_acc_c;
          if (rd_acc_c) ReadBus <= rd_word_c;
        end
      end
    end else begin : g_rd_2stage
      logic [DATA_W-1:0] s1_data;
      logic              s1_valid;

      // Two output stages: capture stage followed by the output register.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          s1_data  <= '0;
          s1_valid <= 1'b0;
          ReadBus  <= '0;
          RValid   <= 1'b0;
        end else begin
          s1_valid <= rd_acc_c;
          if (rd_acc_c) s1_data <= rd_word_c;
          RValid <= s1_valid;
          if (s1_valid) ReadBus <= s1_data;
        end
      end
    end
  endgenerate

endmodule
